// File: rtl/memorydata_param.sv
// Parametrised data memory: hardware clear sweep after reset, registered read port
// with valid strobe, busy flag and out-of-range detection. MEMDATA_PIPE_EN adds an output stage.
module memorydata_param #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Rm,
    input  logic              Wm,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] RegVal,
    output logic [DATA_W-1:0] Data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

    localparam logic STATE_CLEAR = 1'b0;
    localparam logic STATE_READY = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              state_q, state_d;
    logic [ADDR_W:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              vld_q, vld_d;
    logic              err_q, err_d;

    logic              in_range;
    logic [IDX_W-1:0]  rd_idx;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [DATA_W-1:0] mem_wdata;

    // Full-width unsigned compare; always true when DEPTH covers the whole address space.
    assign in_range = ({1'b0, address} < DEPTH_C);
    assign rd_idx   = address[IDX_W-1:0];

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        dout_d    = dout_q;
        vld_d     = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_widx  = rd_idx;
        mem_wdata = RegVal;
        case (state_q)
            STATE_CLEAR: begin
                mem_we    = 1'b1;
                mem_widx  = clr_ptr_q[IDX_W-1:0];
                mem_wdata = INIT_VAL;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_C)
                    state_d = STATE_READY;
            end
            default: begin
                if (Rm) begin
                    // Read wins over a simultaneous write.
                    vld_d  = 1'b1;
                    err_d  = ~in_range;
                    dout_d = in_range ? mem[rd_idx] : '0;
                end else if (Wm) begin
                    err_d  = ~in_range;
                    mem_we = in_range;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= STATE_CLEAR;
            clr_ptr_q <= '0;
            dout_q    <= '0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            dout_q    <= dout_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
        end
    end

    // Storage has no reset; only the clear sweep initialises it.
    always_ff @(posedge clock) begin
        if (mem_we && !reset)
            mem[mem_widx] <= mem_wdata;
    end

`ifdef MEMDATA_PIPE_EN
    logic [DATA_W-1:0] dout2_q;
    logic              vld2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            dout2_q <= '0;
            vld2_q  <= 1'b0;
        end else begin
            dout2_q <= dout_q;
            vld2_q  <= vld_q;
        end
    end

    assign Data_out = dout2_q;
    assign rd_valid = vld2_q;
`else
    assign Data_out = dout_q;
    assign rd_valid = vld_q;
`endif

    assign err  = err_q;
    assign busy = (state_q == STATE_CLEAR);

endmodule

// File: tb/tb_memorydata_param.sv
// Bench for memorydata_param: two instances (DEPTH 256 and 200) share stimulus;
// reads are scoreboarded with expected data and arrival cycle.
module tb_memorydata_param;

`ifdef MEMDATA_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clock = 1'b0;
    logic       reset, Rm, Wm;
    logic [7:0] address, RegVal;
    logic [7:0] Data_out_a, Data_out_b;
    logic       rd_valid_a, rd_valid_b, busy_a, busy_b, err_a, err_b;

    memorydata_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .INIT_VAL(8'hA5)) u_a (
        .clock(clock), .reset(reset), .Rm(Rm), .Wm(Wm), .address(address), .RegVal(RegVal),
        .Data_out(Data_out_a), .rd_valid(rd_valid_a), .busy(busy_a), .err(err_a));

    memorydata_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .INIT_VAL(8'hA5)) u_b (
        .clock(clock), .reset(reset), .Rm(Rm), .Wm(Wm), .address(address), .RegVal(RegVal),
        .Data_out(Data_out_b), .rd_valid(rd_valid_b), .busy(busy_b), .err(err_b));

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    typedef struct {
        logic [7:0] d;
        int         due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always @(negedge clock) begin
        if (rd_valid_a === 1'b1) begin
            if (qa.size() == 0) check("a_spurious_rd_valid", rd_valid_a, 0);
            else begin
                ea = qa.pop_front();
                check("a_rd_data", Data_out_a, ea.d);
                check("a_rd_latency", cyc, ea.due);
            end
        end
    end

    always @(negedge clock) begin
        if (rd_valid_b === 1'b1) begin
            if (qb.size() == 0) check("b_spurious_rd_valid", rd_valid_b, 0);
            else begin
                eb = qb.pop_front();
                check("b_rd_data", Data_out_b, eb.d);
                check("b_rd_latency", cyc, eb.due);
            end
        end
    end

    typedef struct {
        bit         rm, wm;
        logic [7:0] addr, wd, da, db;
        bit         ea, eb;
    } vec_t;

    vec_t tbl[20];

    // Counts edges after reset release until busy drops; also flags any output activity.
    task automatic sweep(input int clr_stop, output int la, output int lb, output int spur);
        int n;
        n = 0; la = 0; lb = 0; spur = 0;
        while (n < 400 && (la == 0 || lb == 0)) begin
            @(posedge clock); #1;
            n++;
            if (n == clr_stop) begin Rm = 0; Wm = 0; end
            if (rd_valid_a !== 1'b0 || err_a !== 1'b0 || rd_valid_b !== 1'b0 || err_b !== 1'b0) spur++;
            if (la == 0 && Data_out_a !== 8'h00 && clr_stop == 0) spur++;
            if (la == 0 && busy_a === 1'b0) la = n;
            if (lb == 0 && busy_b === 1'b0) lb = n;
        end
    endtask

    initial begin
        int la, lb, spur;
        exp_t e;

        tbl[0]  = '{1, 0, 8'd3,   8'h00, 8'hA5, 8'hA5, 0, 0};
        tbl[1]  = '{0, 1, 8'd7,   8'h3C, 8'h00, 8'h00, 0, 0};
        tbl[2]  = '{1, 0, 8'd7,   8'h00, 8'h3C, 8'h3C, 0, 0};
        tbl[3]  = '{0, 1, 8'd9,   8'h01, 8'h00, 8'h00, 0, 0};
        tbl[4]  = '{1, 1, 8'd9,   8'hFF, 8'h01, 8'h01, 0, 0};
        tbl[5]  = '{1, 0, 8'd9,   8'h00, 8'h01, 8'h01, 0, 0};
        tbl[6]  = '{0, 1, 8'd210, 8'h77, 8'h00, 8'h00, 0, 1};
        tbl[7]  = '{1, 0, 8'd250, 8'h00, 8'hA5, 8'h00, 0, 1};
        tbl[8]  = '{1, 0, 8'd210, 8'h00, 8'h77, 8'h00, 0, 1};
        tbl[9]  = '{1, 0, 8'd0,   8'h00, 8'hA5, 8'hA5, 0, 0};
        tbl[10] = '{1, 0, 8'd128, 8'h00, 8'hA5, 8'hA5, 0, 0};
        tbl[11] = '{1, 0, 8'd255, 8'h00, 8'hA5, 8'h00, 0, 1};
        tbl[12] = '{0, 1, 8'd199, 8'h5A, 8'h00, 8'h00, 0, 0};
        tbl[13] = '{1, 0, 8'd199, 8'h00, 8'h5A, 8'h5A, 0, 0};
        tbl[14] = '{1, 0, 8'd200, 8'h00, 8'hA5, 8'h00, 0, 1};
        tbl[15] = '{0, 0, 8'd0,   8'h00, 8'h00, 8'h00, 0, 0};
        tbl[16] = '{0, 1, 8'd0,   8'hE1, 8'h00, 8'h00, 0, 0};
        tbl[17] = '{1, 0, 8'd0,   8'h00, 8'hE1, 8'hE1, 0, 0};
        tbl[18] = '{1, 0, 8'd7,   8'h00, 8'h3C, 8'h3C, 0, 0};
        tbl[19] = '{0, 0, 8'd7,   8'h00, 8'h00, 8'h00, 0, 0};

        reset = 1; Rm = 0; Wm = 0; address = 0; RegVal = 0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy_a", busy_a, 1);      check("rst_busy_b", busy_b, 1);
        check("rst_dout_a", Data_out_a, 0);  check("rst_dout_b", Data_out_b, 0);
        check("rst_vld_a", rd_valid_a, 0);   check("rst_err_a", err_a, 0);

        // Clear sweep with read/write requests held during the first 50 cycles.
        @(negedge clock);
        reset = 0; Rm = 1; Wm = 1; address = 8'd3; RegVal = 8'h11;
        sweep(50, la, lb, spur);
        check("clear_len_a", la, 256);
        check("clear_len_b", lb, 200);
        check("busy_ignored_activity", spur, 0);

        foreach (tbl[i]) begin
            @(negedge clock);
            Rm = tbl[i].rm; Wm = tbl[i].wm; address = tbl[i].addr; RegVal = tbl[i].wd;
            if (tbl[i].rm) begin
                e.due = cyc + LAT;
                e.d = tbl[i].da; qa.push_back(e);
                e.d = tbl[i].db; qb.push_back(e);
            end
            @(posedge clock); #1;
            check($sformatf("err_a_vec%0d", i), err_a, tbl[i].ea);
            check($sformatf("err_b_vec%0d", i), err_b, tbl[i].eb);
        end

        repeat (LAT + 3) @(negedge clock);
        check("hold_dout_a", Data_out_a, 8'h3C);
        check("hold_dout_b", Data_out_b, 8'h3C);
        check("idle_vld_a", rd_valid_a, 0);
        check("drain_a", qa.size(), 0);
        check("drain_b", qb.size(), 0);

        // Reset coinciding with a read drops it, then reset again mid-clear.
        Rm = 1; address = 8'd7; reset = 1;
        @(posedge clock); #1;
        check("rst_read_dout_a", Data_out_a, 0);
        check("rst_read_vld_a", rd_valid_a, 0);
        check("rst_read_busy_b", busy_b, 1);
        @(negedge clock);
        Rm = 0; reset = 0;
        repeat (100) @(posedge clock);
        @(negedge clock);
        reset = 1;
        @(posedge clock);
        @(negedge clock);
        reset = 0;
        sweep(0, la, lb, spur);
        check("reclear_len_a", la, 256);
        check("reclear_len_b", lb, 200);
        check("reclear_quiet", spur, 0);

        @(negedge clock);
        Rm = 1; address = 8'd7;
        e.due = cyc + LAT; e.d = 8'hA5;
        qa.push_back(e); qb.push_back(e);
        @(negedge clock);
        Rm = 0;
        repeat (LAT + 2) @(negedge clock);
        check("final_drain_a", qa.size(), 0);
        check("final_drain_b", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/memorydata_param.md
Name: memorydata_param

Overview:
- Parametrised next-generation data memory for the processor datapath; replaces the fixed 8-bit by 256-entry data store.
- Adds configurable data width and depth, and a hardware clear sequence after reset.
- Adds a read-valid strobe, a busy flag and out-of-range address detection.
- Sits between the control unit (Rm/Wm strobes) and the register file (RegVal in, Data_out back).

Parameters:
- DATA_W, 8, width of each word and of the RegVal/Data_out buses.
- ADDR_W, 8, address bus width.
- DEPTH, 256, number of implemented words; must satisfy 1 <= DEPTH <= 2^ADDR_W.
- INIT_VAL, 0, DATA_W-bit value written to every word during the clear sequence.

Ports:
- clock, input, 1, single system clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- Rm, input, 1, read request, sampled on the rising edge.
- Wm, input, 1, write request, sampled on the rising edge.
- address, input, ADDR_W, word address.
- RegVal, input, DATA_W, write data.
- Data_out, output, DATA_W, read data; registered, and holds its value between reads.
- rd_valid, output, 1, one-cycle pulse marking new read data on Data_out.
- busy, output, 1, high while the clear sequence runs; requests are ignored while high.
- err, output, 1, one-cycle pulse when an accepted request has address >= DEPTH.

Behaviour:
- Clock and reset:
  - One clock, clock.
  - reset is synchronous and active-high; it is sampled only on the rising edge of clock.
- Reset values, applied on any edge with reset=1:
  - Data_out=0, rd_valid=0, err=0, busy=1.
  - FSM goes to CLEAR with clear pointer clr_ptr=0.
  - Reset asserted mid-clear restarts the sweep at 0.
  - Reset asserted mid-read drops that read: no rd_valid, Data_out=0.
- FSM states: CLEAR, READY.
- CLEAR state:
  - Each cycle writes mem[clr_ptr]=INIT_VAL, then clr_ptr increments.
  - After the cycle that writes DEPTH-1, transition to READY; busy falls on that same edge.
  - With reset released at edge 0, busy is high through edge DEPTH and low after it, giving exactly DEPTH clear cycles.
  - Rm and Wm are ignored: no memory write, no rd_valid, no err; the requests are not queued.
- READY state, decided on each edge:
  - Rm=1, address<DEPTH: Data_out<=mem[address] and rd_valid<=1 on the same edge. Read latency is 1 edge.
  - Rm=1, address>=DEPTH: Data_out<=0, rd_valid<=1, err<=1.
  - Rm=0, Wm=1, address<DEPTH: mem[address]<=RegVal. Data_out is unchanged.
  - Rm=0, Wm=1, address>=DEPTH: write is discarded, err<=1.
  - Rm=1 and Wm=1 together: read wins and the write is dropped.
  - Neither Rm nor Wm: rd_valid<=0 and err<=0; Data_out holds.
- Write then read of the same address on consecutive edges returns the new value.
- Address arithmetic:
  - Comparison against DEPTH is unsigned at full ADDR_W width.
  - When DEPTH=2^ADDR_W, err never asserts.
  - clr_ptr is ADDR_W+1 bits wide so the terminal count does not wrap.
- Memory contents are not touched by reset itself, only by the clear sweep.

Optional Feature:
- Macro: MEMDATA_PIPE_EN.
- Defined:
  - Adds a second output register stage.
  - Data_out and rd_valid appear 2 edges after the Rm edge; err keeps its 1-edge timing.
  - Back-to-back reads stream out one per cycle.
  - Reset clears both stages.
- Undefined: read latency is 1 edge exactly as specified above.

Test Plan:
- Clear sweep:
  - Stimulus: DEPTH=256, INIT_VAL=8'hA5; release reset; hold Rm/Wm idle.
  - Response: busy is high for exactly 256 cycles. Then read 0, 128 and 255: each returns 8'hA5 with one rd_valid pulse each.
- Requests while busy:
  - Stimulus: during CLEAR, Wm=1, address=3, RegVal=8'h11; also Rm=1.
  - Response: no rd_valid and no err. After busy falls, reading address 3 returns INIT_VAL.
- Write/read and latency:
  - Stimulus: in READY, write 8'h3C to address 7; read address 7 on the next edge.
  - Response: Data_out=8'h3C with rd_valid=1 after 1 edge (2 edges with MEMDATA_PIPE_EN). Data_out holds afterwards while idle.
- Simultaneous Rm and Wm:
  - Stimulus: mem[9]=8'h01; assert Rm=1, Wm=1, address=9, RegVal=8'hFF.
  - Response: Data_out=8'h01; a later read of address 9 still returns 8'h01.
- Out-of-range access:
  - Stimulus: DEPTH=200; write address 210; then read address 250.
  - Response: err pulses on both edges. The read gives Data_out=0 with rd_valid=1. No in-range word changes.
- Reset mid-clear:
  - Stimulus: pulse reset at clear cycle 100.
  - Response: busy stays high for 256 more cycles, Data_out=0 and rd_valid=0 throughout.
